// File: rtl/csr_regfile_pkg.sv
// Shared parameters, CSR addresses, field positions and the
// request/response bundles exchanged with the CSR unit.
package COMMON_PARAMS;
    localparam int unsigned XLEN = 32;
endpackage

package CSR_PROPS;
    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MISA      = 12'h301;
    localparam logic [11:0] ADDR_MIE       = 12'h304;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MTVAL     = 12'h343;
    localparam logic [11:0] ADDR_MIP       = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

    typedef enum logic [11:0] {
        CSR_MSTATUS   = ADDR_MSTATUS,
        CSR_MISA      = ADDR_MISA,
        CSR_MIE       = ADDR_MIE,
        CSR_MTVEC     = ADDR_MTVEC,
        CSR_MSCRATCH  = ADDR_MSCRATCH,
        CSR_MEPC      = ADDR_MEPC,
        CSR_MCAUSE    = ADDR_MCAUSE,
        CSR_MTVAL     = ADDR_MTVAL,
        CSR_MIP       = ADDR_MIP,
        CSR_MCYCLE    = ADDR_MCYCLE,
        CSR_MINSTRET  = ADDR_MINSTRET,
        CSR_MCYCLEH   = ADDR_MCYCLEH,
        CSR_MINSTRETH = ADDR_MINSTRETH,
        CSR_MHARTID   = ADDR_MHARTID
    } csr_name_e;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MSTATUS_MPP0 = 11;
    localparam int MSTATUS_MPP1 = 12;
    localparam int MIE_MSIE     = 3;
    localparam int MIE_MTIE     = 7;
    localparam int MIE_MEIE     = 11;

    localparam logic [31:0] MISA_RV32I = 32'h4000_0100;

    typedef struct packed {
        logic      valid;
        csr_name_e csr_name;
    } csr_read_req_t;

    typedef struct packed {
        logic                            valid;
        csr_name_e                       csr_name;
        logic [COMMON_PARAMS::XLEN-1:0]  data;
    } csr_write_req_t;

    typedef struct packed {
        logic                            valid;
        logic [COMMON_PARAMS::XLEN-1:0]  data;
    } csr_read_res_t;

    // {meie, mtie, msie} spread onto their architectural bit slots
    function automatic logic [COMMON_PARAMS::XLEN-1:0] irq_vec(
        input logic [2:0] b
    );
        logic [COMMON_PARAMS::XLEN-1:0] v;
        v = '0;
        v[MIE_MEIE] = b[2];
        v[MIE_MTIE] = b[1];
        v[MIE_MSIE] = b[0];
        return v;
    endfunction

    function automatic logic [COMMON_PARAMS::XLEN-1:0] mstatus_vec(
        input logic mie,
        input logic mpie
    );
        logic [COMMON_PARAMS::XLEN-1:0] v;
        v = '0;
        v[MSTATUS_MIE]  = mie;
        v[MSTATUS_MPIE] = mpie;
        v[MSTATUS_MPP0] = 1'b1;
        v[MSTATUS_MPP1] = 1'b1;
        return v;
    endfunction
endpackage

// File: rtl/csr_csru_if.sv
// Handshake bundle between the CSR unit and the CSR register file.
interface csr_csru_if;
    import CSR_PROPS::*;

    csr_read_req_t  read_req;
    csr_write_req_t write_req;
    csr_read_res_t  read_res;

    modport csrrf (
        input  read_req,
        input  write_req,
        output read_res
    );

    modport csru (
        output read_req,
        output write_req,
        input  read_res
    );
endinterface

// File: rtl/csr_counter64.sv
// Free-running 64-bit counter with independently writable halves;
// a write to a half overrides that half's increment and carry.
module csr_counter64 #(
    parameter int unsigned HW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inc_i,
    input  logic            wr_lo_i,
    input  logic            wr_hi_i,
    input  logic [HW-1:0]   wdata_i,
    output logic [2*HW-1:0] cnt_o
);
    logic [HW-1:0] lo_q, lo_d;
    logic [HW-1:0] hi_q, hi_d;
    logic          carry;

    always_comb begin
        carry = inc_i & (&lo_q) & ~wr_lo_i;
        lo_d  = wr_lo_i ? wdata_i : lo_q + {{(HW-1){1'b0}}, inc_i};
        hi_d  = wr_hi_i ? wdata_i : hi_q + {{(HW-1){1'b0}}, carry};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_q <= '0;
            hi_q <= '0;
        end else begin
            lo_q <= lo_d;
            hi_q <= hi_d;
        end
    end

    assign cnt_o = {hi_q, lo_q};
endmodule

// File: rtl/csr_regfile.sv
// Machine-mode CSR file: trap/mret state, interrupt enables,
// cycle/instret counters and a one-cycle registered read port.
module csr_regfile
    import CSR_PROPS::*;
#(
    parameter int unsigned XLEN    = COMMON_PARAMS::XLEN,
    parameter int unsigned HART_ID = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    csr_csru_if.csrrf       csru,
    input  logic            instret_i,
    input  logic            trap_valid_i,
    input  logic [XLEN-1:0] trap_cause_i,
    input  logic [XLEN-1:0] trap_pc_i,
    input  logic [XLEN-1:0] trap_tval_i,
    input  logic            mret_i,
    input  logic [2:0]      irq_i,
    output logic [XLEN-1:0] mtvec_o,
    output logic [XLEN-1:0] mepc_o,
    output logic            irq_pending_o
);
    logic            wen;
    csr_name_e       wname;
    logic [XLEN-1:0] wdata;
    logic            ctl_busy;

    logic            mie_q, mie_d;
    logic            mpie_q, mpie_d;
    logic [2:0]      ien_q, ien_d;
    logic [2:0]      mip_q;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mtval_q, mtval_d;
    logic            rd_valid_q, rd_valid_d;
    logic [XLEN-1:0] rd_data_q, rd_data_d;
    logic [XLEN-1:0] rdata;
    logic [2*XLEN-1:0] mcycle;
    logic [2*XLEN-1:0] minstret;

    assign wen      = csru.write_req.valid;
    assign wname    = csru.write_req.csr_name;
    assign wdata    = csru.write_req.data;
    assign ctl_busy = trap_valid_i | mret_i;

    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        ien_d      = ien_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        if (trap_valid_i) begin
            mpie_d   = mie_q;
            mie_d    = 1'b0;
            mepc_d   = trap_pc_i & ~XLEN'(3);
            mcause_d = trap_cause_i;
            mtval_d  = trap_tval_i;
        end else if (mret_i) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end
        if (wen) begin
            unique case (wname)
                CSR_MSTATUS: if (!ctl_busy) begin
                    mie_d  = wdata[MSTATUS_MIE];
                    mpie_d = wdata[MSTATUS_MPIE];
                end
                CSR_MEPC:   if (!ctl_busy) mepc_d = wdata & ~XLEN'(3);
                CSR_MCAUSE: if (!ctl_busy) mcause_d = wdata;
                CSR_MTVAL:  if (!ctl_busy) mtval_d = wdata;
                CSR_MIE: ien_d = {wdata[MIE_MEIE], wdata[MIE_MTIE],
                                  wdata[MIE_MSIE]};
                CSR_MTVEC:    mtvec_d = wdata & ~XLEN'(3);
                CSR_MSCRATCH: mscratch_d = wdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        unique case (csru.read_req.csr_name)
            CSR_MSTATUS:   rdata = mstatus_vec(mie_q, mpie_q);
            CSR_MISA:      rdata = MISA_RV32I;
            CSR_MIE:       rdata = irq_vec(ien_q);
            CSR_MTVEC:     rdata = mtvec_q;
            CSR_MSCRATCH:  rdata = mscratch_q;
            CSR_MEPC:      rdata = mepc_q;
            CSR_MCAUSE:    rdata = mcause_q;
            CSR_MTVAL:     rdata = mtval_q;
            CSR_MIP:       rdata = irq_vec(mip_q);
            CSR_MCYCLE:    rdata = mcycle[XLEN-1:0];
            CSR_MCYCLEH:   rdata = mcycle[2*XLEN-1:XLEN];
            CSR_MINSTRET:  rdata = minstret[XLEN-1:0];
            CSR_MINSTRETH: rdata = minstret[2*XLEN-1:XLEN];
            CSR_MHARTID:   rdata = XLEN'(HART_ID);
            default:       rdata = '0;
        endcase
        rd_valid_d = csru.read_req.valid;
        rd_data_d  = rd_valid_d ? rdata : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            ien_q      <= '0;
            mip_q      <= '0;
            mtvec_q    <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            ien_q      <= ien_d;
            mip_q      <= irq_i;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    csr_counter64 #(.HW(XLEN)) u_mcycle (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (1'b1),
        .wr_lo_i (wen && wname == CSR_MCYCLE),
        .wr_hi_i (wen && wname == CSR_MCYCLEH),
        .wdata_i (wdata),
        .cnt_o   (mcycle)
    );

    csr_counter64 #(.HW(XLEN)) u_minstret (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (instret_i),
        .wr_lo_i (wen && wname == CSR_MINSTRET),
        .wr_hi_i (wen && wname == CSR_MINSTRETH),
        .wdata_i (wdata),
        .cnt_o   (minstret)
    );

    assign csru.read_res.valid = rd_valid_q;
    assign csru.read_res.data  = rd_data_q;
    assign mtvec_o       = mtvec_q;
    assign mepc_o        = mepc_q;
    assign irq_pending_o = mie_q & |(mip_q & ien_q);
endmodule

// File: doc/csr_regfile.md
CSR_REGFILE -- requirements
Module: csr_regfile

Interface
REQ-001 SHALL have parameter XLEN, default COMMON_PARAMS::XLEN (32), meaning the CSR data width.
REQ-002 SHALL have parameter HART_ID, default 0, meaning the value returned by mhartid.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port clk, input, 1 bit: clock.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port csru, csr_csru_if.csrrf: read_req and write_req come in, read_res goes out.
REQ-007 SHALL have port instret_i, input, 1 bit: one instruction retired this cycle.
REQ-008 SHALL have port trap_valid_i, input, 1 bit: trap taken this cycle.
REQ-009 SHALL have port trap_cause_i, input, XLEN bits: mcause value for the trap.
REQ-010 SHALL have port trap_pc_i, input, XLEN bits: PC of the trapping instruction.
REQ-011 SHALL have port trap_tval_i, input, XLEN bits: mtval value for the trap.
REQ-012 SHALL have port mret_i, input, 1 bit: mret retired this cycle.
REQ-013 SHALL have port irq_i, input, 3 bits: {external, timer, software} interrupt lines.
REQ-014 SHALL have port mtvec_o, output, XLEN bits: current mtvec value.
REQ-015 SHALL have port mepc_o, output, XLEN bits: current mepc value.
REQ-016 SHALL have port irq_pending_o, output, 1 bit: (mip & mie) != 0 and mstatus.MIE == 1.

Function
REQ-017 Implemented CSRs SHALL be: mstatus, misa, mie, mtvec, mscratch, mepc, mcause, mtval, mip, mcycle, mcycleh, minstret, minstreth and mhartid.
REQ-018 Read latency SHALL be 1 cycle: read_res.valid(t+1) = read_req.valid(t), and read_res.data(t+1) = value of CSR read_req.csr_name at cycle t.
REQ-019 read_res.data SHALL be 0 when read_res.valid = 0, and it SHALL hold no stale value.
REQ-020 A write with write_req.valid at cycle t SHALL be visible from cycle t+1.
REQ-021 A read and a write to the same CSR in the same cycle SHALL return the old value.
REQ-022 An unimplemented csr_name SHALL read 0, and a write to it SHALL be ignored.
REQ-023 Writes to misa, mhartid and mip SHALL be ignored (read-only).
REQ-024 mstatus WARL: only MIE[3] and MPIE[7] SHALL be writable; MPP[12:11] SHALL read 2'b11; all other bits SHALL read 0.
REQ-025 mie: only bits 3, 7 and 11 SHALL be writable; all other bits SHALL read 0.
REQ-026 mip SHALL read {irq_i[2] at bit 11, irq_i[1] at bit 7, irq_i[0] at bit 3}, registered one cycle.
REQ-027 mtvec[1:0] and mepc[1:0] SHALL be forced to 0 on write (direct mode only).
REQ-028 misa SHALL read RV32I (0x4000_0100).
REQ-029 mcycle SHALL increment every cycle as a 64-bit {mcycleh, mcycle}.
REQ-030 The low half of mcycle SHALL wrap 0xFFFF_FFFF to 0 with a carry into mcycleh; the 64-bit value SHALL wrap to 0.
REQ-031 minstret SHALL behave as mcycle, but increment only when instret_i = 1.
REQ-032 A CSR write to a counter half SHALL take priority over the increment that cycle: the written value SHALL appear, with no increment and no carry applied to that half.
REQ-033 On trap_valid_i: mepc <= trap_pc_i & ~3, mcause <= trap_cause_i, mtval <= trap_tval_i, MPIE <= MIE, MIE <= 0.
REQ-034 On mret_i: MIE <= MPIE and MPIE <= 1.
REQ-035 Priority SHALL be trap_valid_i > mret_i > CSR write for mstatus, mepc, mcause and mtval.
REQ-036 A CSR write to any other register in the same cycle as a trap or mret SHALL still take effect.

Reset
REQ-037 On rst_n low, all writable CSRs and the counters SHALL be 0 and mtvec SHALL be 0.
REQ-038 On rst_n low, read_res.valid = 0, read_res.data = 0 and irq_pending_o = 0, immediately and asynchronously.
REQ-039 Reset asserted mid-read SHALL discard the pending response: no read_res.valid appears after release.

Structure
REQ-040 CSR addresses, csr_name_e, the mstatus/mie bit positions and the misa constant SHALL reside in package CSR_PROPS; XLEN SHALL reside in COMMON_PARAMS.
REQ-041 The 64-bit counter with a write port SHALL be one sub-module, csr_counter64, instantiated twice (mcycle and minstret).

Verification
REQ-042 Write mscratch = 0xDEAD_BEEF, then read it -> read_res.valid one cycle after the request, data = 0xDEAD_BEEF.
REQ-043 Write mcycle = 0xFFFF_FFFE, mcycleh = 5 -> two cycles later a read returns mcycle 0 and mcycleh 6.
REQ-044 Write mstatus = 0xFFFF_FFFF -> reads back 0x0000_1888.
REQ-045 Write mstatus.MIE = 1, then assert trap_valid_i with trap_pc_i = 0x103 -> mepc = 0x100 and mstatus = 0x1880; after mret_i -> mstatus = 0x1888.
REQ-046 Read and write mepc in the same cycle -> read returns the old value; the next read returns the new value.
REQ-047 Read an unimplemented CSR -> data 0; write misa -> misa still reads 0x4000_0100.
